// File: rtl/uart_rx.sv
// uart_rx: oversampled UART receiver with 2-of-3 majority voting, optional parity and one-cycle status pulses
module uart_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err,
  output logic                  busy
);
  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] S0 = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] S1 = CW'(OVERSAMPLE / 2);
  localparam logic [CW-1:0] S2 = CW'(OVERSAMPLE / 2 + 1);
  localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);
  localparam logic [2:0] IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PARITY = 3'd3, STOP = 3'd4;
  logic [2:0] state;
  logic [CW-1:0] edge_cnt, edge_nxt;
  logic [BW-1:0] bit_cnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic s0, s1, line_hi, par_en_q, par_typ_q, par_bad;
  logic maj, vote, bit_end, start_det;
  assign maj = (s0 & s1) | (s0 & RX_IN) | (s1 & RX_IN);
  assign vote = edge_cnt == S2;
  assign bit_end = edge_cnt == LAST;
  assign edge_nxt = bit_end ? '0 : edge_cnt + 1'b1;
  // line_hi blocks a start until the line has been seen high, so a frame cut by reset is ignored
  assign start_det = state == IDLE && !RX_IN && line_hi;
  assign busy = state != IDLE;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      edge_cnt <= '0;
      bit_cnt <= '0;
      shreg <= '0;
      P_DATA <= '0;
      data_valid <= 1'b0;
      par_err <= 1'b0;
      stp_err <= 1'b0;
      s0 <= 1'b0;
      s1 <= 1'b0;
      line_hi <= 1'b0;
      par_en_q <= 1'b0;
      par_typ_q <= 1'b0;
      par_bad <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      par_err <= 1'b0;
      stp_err <= 1'b0;
      line_hi <= (line_hi & ~start_det) | RX_IN;
      if (edge_cnt == S0) s0 <= RX_IN;
      if (edge_cnt == S1) s1 <= RX_IN;
      case (state)
        IDLE: if (start_det) begin
          state <= START;
          edge_cnt <= CW'(1);
          bit_cnt <= '0;
          par_bad <= 1'b0;
          par_en_q <= PAR_EN;
          par_typ_q <= PAR_TYP;
        end
        START: begin
          edge_cnt <= vote && maj ? '0 : edge_nxt;
          state <= vote && maj ? IDLE : bit_end ? DATA : START;
        end
        DATA: begin
          edge_cnt <= edge_nxt;
          if (vote) shreg[bit_cnt] <= maj;
          if (bit_end) bit_cnt <= bit_cnt + 1'b1;
          if (bit_end && bit_cnt == LAST_BIT) state <= par_en_q ? PARITY : STOP;
        end
        PARITY: begin
          edge_cnt <= edge_nxt;
          if (vote) par_bad <= maj ^ (^shreg) ^ par_typ_q;
          if (bit_end) state <= STOP;
        end
        STOP: begin
          edge_cnt <= vote ? '0 : edge_nxt;
          if (vote) begin
            state <= IDLE;
            stp_err <= ~maj;
            par_err <= par_bad;
            data_valid <= maj & ~par_bad;
            if (maj & ~par_bad) P_DATA <= shreg;
          end
        end
        default: begin
          state <= IDLE;
          edge_cnt <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: vector table, corner sequences and random frames against a frame-level reference model
module tb_uart_rx;
  localparam int DW = 8;
  localparam int OS = 8;
  logic clk, rst, RX_IN, PAR_EN, PAR_TYP;
  logic [DW-1:0] P_DATA;
  logic data_valid, par_err, stp_err, busy;
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  int dv_q[$], pe_q[$], se_q[$];
  logic [DW-1:0] dv_d[$];
  typedef struct {
    logic [7:0] d;
    logic pe, typ, flip, stp, ev, epe, ese;
    logic [7:0] ep;
    int tick;
  } vec_t;
  vec_t tbl[7];

  uart_rx #(.DATA_WIDTH(DW), .OVERSAMPLE(OS)) dut (
    .clk(clk), .rst(rst), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
    .P_DATA(P_DATA), .data_valid(data_valid), .par_err(par_err), .stp_err(stp_err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) if (rst) begin
    if (data_valid) begin
      dv_q.push_back(cyc);
      dv_d.push_back(P_DATA);
      chk("dv_excl_err", {30'd0, par_err, stp_err}, 32'd0);
    end
    if (par_err) pe_q.push_back(cyc);
    if (stp_err) se_q.push_back(cyc);
  end

  task automatic clear_q();
    dv_q.delete();
    dv_d.delete();
    pe_q.delete();
    se_q.delete();
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pe, input logic typ, input logic flip,
                            input logic stp, output int t0);
    PAR_EN = pe;
    PAR_TYP = typ;
    RX_IN = 1'b0;
    t0 = cyc + 1;
    repeat (OS) @(negedge clk);
    for (int i = 0; i < DW; i++) begin
      RX_IN = d[i];
      repeat (OS) @(negedge clk);
    end
    if (pe) begin
      RX_IN = (^d) ^ typ ^ flip;
      repeat (OS) @(negedge clk);
    end
    RX_IN = stp;
    repeat (OS) @(negedge clk);
    RX_IN = 1'b1;
  endtask

  task automatic run_frame(input logic [7:0] d, input logic pe, input logic typ, input logic flip,
                           input logic stp, input logic ev, input logic epe, input logic ese,
                           input logic [7:0] ep, input int etick, input string tag);
    int t0, act_tick;
    clear_q();
    send_frame(d, pe, typ, flip, stp, t0);
    act_tick = dv_q.size() > 0 ? dv_q[0] - t0 : pe_q.size() > 0 ? pe_q[0] - t0 :
               se_q.size() > 0 ? se_q[0] - t0 : -1;
    chk({tag, " dv_count"}, dv_q.size(), {31'd0, ev});
    chk({tag, " par_err_count"}, pe_q.size(), {31'd0, epe});
    chk({tag, " stp_err_count"}, se_q.size(), {31'd0, ese});
    chk({tag, " event_tick"}, act_tick, (ev | epe | ese) ? etick : -1);
    chk({tag, " P_DATA"}, {24'd0, P_DATA}, {24'd0, ep});
    repeat (12) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int ta, tb, t0, a0, a1;
    logic [7:0] d, exp_p;
    logic pe, typ, flip, stp, ev;
    tbl[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA5, 77};
    tbl[1] = '{8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h3C, 85};
    tbl[2] = '{8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h3C, 85};
    tbl[3] = '{8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h3C, 77};
    tbl[4] = '{8'h96, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h96, 85};
    tbl[5] = '{8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h96, 85};
    tbl[6] = '{8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hFF, 77};
    rst = 1'b0;
    RX_IN = 1'b1;
    PAR_EN = 1'b0;
    PAR_TYP = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset P_DATA", {24'd0, P_DATA}, 32'd0);
    chk("reset outputs", {28'd0, data_valid, par_err, stp_err, busy}, 32'd0);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 7; i++)
      run_frame(tbl[i].d, tbl[i].pe, tbl[i].typ, tbl[i].flip, tbl[i].stp,
                tbl[i].ev, tbl[i].epe, tbl[i].ese, tbl[i].ep, tbl[i].tick, $sformatf("vec%0d", i));
    clear_q();
    RX_IN = 1'b0;
    t0 = cyc + 1;
    repeat (2) @(negedge clk);
    RX_IN = 1'b1;
    repeat (3) @(negedge clk);
    chk("glitch busy_tick4", {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk("glitch busy_tick5", {31'd0, busy}, 32'd0);
    chk("glitch tick_ref", cyc - t0, 32'd5);
    repeat (10) @(negedge clk);
    chk("glitch pulses", dv_q.size() + pe_q.size() + se_q.size(), 32'd0);
    chk("glitch P_DATA", {24'd0, P_DATA}, 32'hFF);
    fork
      run_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h5A, 77, "par_hold");
      begin
        repeat (20) @(negedge clk);
        PAR_EN = 1'b1;
        PAR_TYP = 1'b1;
      end
    join
    clear_q();
    send_frame(8'h01, 1'b0, 1'b0, 1'b0, 1'b1, ta);
    send_frame(8'hFE, 1'b0, 1'b0, 1'b0, 1'b1, tb);
    repeat (4) @(negedge clk);
    a0 = dv_q.size() > 0 ? dv_q[0] - ta : -1;
    a1 = dv_q.size() > 1 ? dv_q[1] - ta : -1;
    chk("b2b dv_count", dv_q.size(), 32'd2);
    chk("b2b tick0", a0, 32'd77);
    chk("b2b tick1", a1, 32'd157);
    chk("b2b data0", dv_d.size() > 0 ? {24'd0, dv_d[0]} : 32'hDEAD, 32'h01);
    chk("b2b data1", dv_d.size() > 1 ? {24'd0, dv_d[1]} : 32'hDEAD, 32'hFE);
    chk("b2b errors", pe_q.size() + se_q.size(), 32'd0);
    repeat (8) @(negedge clk);
    clear_q();
    PAR_EN = 1'b0;
    RX_IN = 1'b0;
    repeat (OS) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      RX_IN = 1'b1;
      repeat (OS) @(negedge clk);
    end
    RX_IN = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst busy_before", {31'd0, busy}, 32'd1);
    rst = 1'b0;
    #1;
    chk("rst async P_DATA", {24'd0, P_DATA}, 32'd0);
    chk("rst async outputs", {28'd0, data_valid, par_err, stp_err, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (OS * 4 - 3) @(negedge clk);
    chk("rst ignore busy", {31'd0, busy}, 32'd0);
    RX_IN = 1'b1;
    repeat (OS + 4) @(negedge clk);
    chk("rst ignore pulses", dv_q.size() + pe_q.size() + se_q.size(), 32'd0);
    run_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h81, 77, "rst_next");
    exp_p = 8'h81;
    for (int n = 0; n < 30; n++) begin
      d = 8'($urandom);
      pe = 1'($urandom_range(0, 1));
      typ = 1'($urandom_range(0, 1));
      flip = $urandom_range(0, 3) == 0;
      stp = $urandom_range(0, 5) != 0;
      ev = stp && !(pe && flip);
      if (ev) exp_p = d;
      run_frame(d, pe, typ, flip, stp, ev, pe & flip, ~stp, exp_p,
                (DW + 1 + int'(pe)) * OS + OS / 2 + 1, $sformatf("rand%0d", n));
      repeat ($urandom_range(0, 10)) @(negedge clk);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 8, number of data bits per frame.
REQ-002 SHALL provide parameter OVERSAMPLE, default 8, clk cycles per bit period; legal values 8, 16, 32.
REQ-003 SHALL have port clk  input  1  oversample clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port RX_IN  input  1  serial line; idles high; already synchronous to clk.
REQ-006 SHALL have port PAR_EN  input  1  1 = frame carries a parity bit after the data bits.
REQ-007 SHALL have port PAR_TYP  input  1  0 = even parity, 1 = odd parity.
REQ-008 SHALL have port P_DATA  output  DATA_WIDTH  last received data word, registered.
REQ-009 SHALL have port data_valid  output  1  one-cycle pulse: P_DATA holds a good frame.
REQ-010 SHALL have port par_err  output  1  one-cycle pulse: parity mismatch on the frame just ended.
REQ-011 SHALL have port stp_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-012 SHALL have port busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-013 SHALL decode frame format: start bit (0), DATA_WIDTH data bits LSB first, optional parity bit, one stop bit (1).
REQ-014 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP; unused encodings go to IDLE.
REQ-015 SHALL keep an edge counter 0..OVERSAMPLE-1 and a bit counter 0..DATA_WIDTH-1.
REQ-016 SHALL, at the clk edge where IDLE and RX_IN==0, move to START with edge counter = 1; that edge is tick 0 of the frame.
REQ-017 SHALL, with H = OVERSAMPLE/2, sample RX_IN at edge counts H-1, H, H+1 and take the bit value as the 2-of-3 majority at the H+1 edge.
REQ-018 SHALL end each bit when the edge counter reaches OVERSAMPLE-1, then wrap the counter to 0 and advance bit counter or state.
REQ-019 SHALL, in START, return to IDLE at the H+1 edge if the majority is 1 (glitch rejection); no output pulses, P_DATA unchanged.
REQ-020 SHALL, in DATA, shift each majority bit into a data shift register at bit position bit_cnt; go to PARITY after bit DATA_WIDTH-1 if PAR_EN, else to STOP.
REQ-021 SHALL, in PARITY, compare the majority bit against the XOR of the data bits (inverted if PAR_TYP=1) and hold the mismatch result until STOP.
REQ-022 SHALL, in STOP, at the H+1 edge return to IDLE (not waiting for bit end), so a start bit arriving immediately is caught.
REQ-023 SHALL, at that same edge, set stp_err=1 if the stop majority is 0, set par_err=1 if a parity mismatch was recorded, otherwise set data_valid=1 and load P_DATA from the shift register.
REQ-024 SHALL assert data_valid, par_err and stp_err for exactly one cycle, never data_valid together with either error; par_err and stp_err may assert together.
REQ-025 SHALL sample PAR_EN and PAR_TYP at start detection and hold them for the whole frame; mid-frame changes have no effect.
REQ-026 SHALL produce data_valid at tick (DATA_WIDTH+1)*OVERSAMPLE + H + 1 without parity and at tick (DATA_WIDTH+2)*OVERSAMPLE + H + 1 with parity.

Reset
REQ-027 SHALL on rst low force state IDLE, both counters 0, shift register 0, P_DATA 0, and data_valid, par_err, stp_err and busy 0, at any point in a frame.
REQ-028 SHALL, after rst deasserts mid-frame, ignore the rest of that frame until RX_IN goes high and then low again.

Verification
REQ-029 SHALL cover: OVERSAMPLE=8, PAR_EN=0, frame 0xA5 -> data_valid pulse at tick 77, P_DATA=0xA5, no errors.
REQ-030 SHALL cover: PAR_EN=1, PAR_TYP=0, 0x3C with parity bit 0 -> data_valid at tick 85, P_DATA=0x3C; the same frame with parity bit 1 -> par_err pulse, no data_valid, P_DATA unchanged.
REQ-031 SHALL cover: RX_IN low for 2 cycles then high -> return to IDLE at START H+1 edge, busy deasserts, no pulses.
REQ-032 SHALL cover: frame 0x55 with stop bit 0 -> stp_err pulse at tick 77, no data_valid.
REQ-033 SHALL cover: back-to-back frames 0x01 then 0xFE, second start edge at tick 80 -> two data_valid pulses with correct P_DATA each.
REQ-034 SHALL cover: rst asserted at DATA bit 4 -> all outputs 0 at once; the next clean frame 0x81 is received correctly.
